// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY-cycle access, byte-lane writes.
// Optional store-alignment checking is enabled with `define DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned AW    = DEPTH_LOG2 + 2;
   localparam int unsigned CW    = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   logic [CW-1:0]   counter;
   logic [31:0]     lat_addr;
   logic [31:0]     lat_wdata;
   logic            lat_wen;
   logic [3:0]      lat_wstrb;
   logic [31:0]     mem [DEPTH];

   logic                  accept_c;
   logic                  commit_c;
   logic [31:0]           c_addr;
   logic [31:0]           c_wdata;
   logic                  c_wen;
   logic [3:0]            c_wstrb;
   logic [DEPTH_LOG2-1:0] c_idx;
   logic [31:0]           old_c;
   logic [31:0]           merged_c;
   logic                  illegal_c;

   assign req_ready  = reset && (state == IDLE);
   assign resp_valid = reset && (state == RESP);
   assign accept_c   = req_valid && req_ready;

   // Commit uses live request fields on a single-cycle access, latched fields otherwise
   always_comb begin
      c_addr   = lat_addr;
      c_wdata  = lat_wdata;
      c_wen    = lat_wen;
      c_wstrb  = lat_wstrb;
      commit_c = 1'b0;
      if (state == IDLE) begin
         c_addr  = req_addr;
         c_wdata = req_wdata;
         c_wen   = req_wen;
         c_wstrb = req_wstrb;
         commit_c = accept_c && (LATENCY == 1);
      end else if (state == WAIT) begin
         commit_c = reset && (counter == CW'(1));
      end
      c_idx = c_addr[AW-1:2];
      old_c = mem[c_idx];
      merged_c = old_c;
      for (int i = 0; i < 4; i++) begin
         if (c_wstrb[i]) merged_c[8*i +: 8] = c_wdata[8*i +: 8];
      end
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   logic       shape_ok_c;
   logic [1:0] low_lane_c;
   logic       unused_addr_c;

   always_comb begin
      shape_ok_c = (c_wstrb == 4'b0001) || (c_wstrb == 4'b0010) ||
                   (c_wstrb == 4'b0100) || (c_wstrb == 4'b1000) ||
                   (c_wstrb == 4'b0011) || (c_wstrb == 4'b1100) ||
                   (c_wstrb == 4'b1111);
      low_lane_c = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (c_wstrb[i]) low_lane_c = 2'(i);
      end
      illegal_c = c_wen && (c_wstrb != 4'b0000) &&
                  (!shape_ok_c || (c_addr[1:0] != low_lane_c));
   end
   assign unused_addr_c = ^c_addr[31:AW];
`else
   logic unused_addr_c;
   assign illegal_c     = 1'b0;
   assign unused_addr_c = ^{c_addr[31:AW], c_addr[1:0]};
`endif

   // Memory array is never reset; an illegal store leaves it untouched
   always_ff @(posedge clk) begin
      if (commit_c && c_wen && !illegal_c) mem[c_idx] <= merged_c;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         counter    <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  lat_addr  <= req_addr;
                  lat_wen   <= req_wen;
                  lat_wstrb <= req_wstrb;
                  lat_wdata <= req_wdata;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     counter <= CW'(LATENCY - 1);
                     state   <= WAIT;
                  end
               end
            end
            WAIT: begin
               counter <= counter - CW'(1);
               if (counter == CW'(1)) state <= RESP;
            end
            RESP: begin
               if (resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (commit_c) begin
            resp_err   <= illegal_c;
            resp_rdata <= illegal_c ? 32'h0 : (c_wen ? merged_c : old_c);
         end
      end
   end

endmodule
